// File: rtl/fir_decimator.sv
// fir_decimator: keeps one sample in every DECIM from the upstream FIR
// strobe stream and buffers the kept samples in a first-word-fall-through
// FIFO that drains over a valid/ready handshake.
//
// Parameters (the ranges below are not checked in the RTL):
//   WIDTH - sample width, signed two's complement
//   DECIM - decimation ratio, must be >= 1
//   PHASE - index of the kept sample within each group, 0 <= PHASE < DECIM
//   DEPTH - FIFO depth, power of two, >= 2
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   in_valid       one-cycle input strobe
//   data_in        input sample, read only when in_valid=1
//   data_out       FIFO head sample (combinational from storage)
//   out_valid      FIFO not empty
//   out_ready      consumer takes the head sample
//   count          FIFO occupancy, 0..DEPTH
//   overflow       sticky: a kept sample was dropped because the FIFO was full
//   clear_overflow synchronous clear of overflow (a same-cycle drop wins)
module fir_decimator #(
    parameter int WIDTH = 16,
    parameter int DECIM = 8,
    parameter int PHASE = 0,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   data_in,
    output logic signed [WIDTH-1:0]   data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    input  logic                      clear_overflow
);
    // A DECIM of 1 would give a zero-width counter; keep one bit, it stays 0.
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [PW-1:0] PHASE_SEL  = PW'(PHASE);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   FULL       = (AW + 1)'(DEPTH);

    logic [PW-1:0]                 phase;
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]   mem;

    logic keep;
    logic pop;
    logic push;
    logic drop;

    // Keep is decided on the phase value before this strobe's increment.
    assign keep = in_valid && (phase == PHASE_SEL);
    assign pop  = out_valid && out_ready;
    // A full FIFO that is popping this cycle has a free slot at the edge.
    assign push = keep && ((count < FULL) || pop);
    assign drop = keep && (count == FULL) && !pop;

    assign out_valid = (count != '0);
    assign data_out  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (in_valid) begin
            // The counter advances on every strobe, dropped or not.
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator. Three instances share the stimulus:
// u0 (DECIM=8, PHASE=0), u3 (DECIM=8, PHASE=3), u1 (DECIM=1).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, i.e. after the edge has settled.
module tb_fir_decimator;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               out_ready = 1'b0;
    logic               clear_overflow = 1'b0;

    logic signed [15:0] d0, d3, d1;
    logic               v0, v3, v1;
    logic [2:0]         c0, c3, c1;
    logic               o0, o3, o1;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fir_decimator #(.WIDTH(16), .DECIM(8), .PHASE(0), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .data_out(d0), .out_valid(v0), .out_ready(out_ready), .count(c0),
        .overflow(o0), .clear_overflow(clear_overflow));

    fir_decimator #(.WIDTH(16), .DECIM(8), .PHASE(3), .DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .data_out(d3), .out_valid(v3), .out_ready(out_ready), .count(c3),
        .overflow(o3), .clear_overflow(clear_overflow));

    fir_decimator #(.WIDTH(16), .DECIM(1), .PHASE(0), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .data_out(d1), .out_valid(v1), .out_ready(out_ready), .count(c1),
        .overflow(o1), .clear_overflow(clear_overflow));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle input strobe; returns just after the capturing edge.
    task automatic send(input int v);
        in_valid = 1'b1;
        data_in  = 16'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Fill u0 with four kept samples base..base+3 (out_ready must be 0).
    task automatic fill4(input int base);
        for (int k = 0; k < 4; k++) begin
            send(base + k);
            for (int j = 0; j < 7; j++) send(1000);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 32'(c0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_data",  32'(d0), 0);
        chk("rst_ovf",   32'(o0), 0);
        tick();
        rst = 1'b1;
        tick();

        // Basic decimation + phase selection + DECIM=1, ramp every 33 cycles
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(i);
            chk($sformatf("ramp_p0_valid_%0d", i), 32'(v0), 32'((i % 8) == 0));
            if ((i % 8) == 0) chk($sformatf("ramp_p0_data_%0d", i), 32'(d0), 32'(i));
            chk($sformatf("ramp_p3_valid_%0d", i), 32'(v3), 32'((i % 8) == 3));
            if ((i % 8) == 3) chk($sformatf("ramp_p3_data_%0d", i), 32'(d3), 32'(i));
            chk($sformatf("ramp_d1_valid_%0d", i), 32'(v1), 1);
            chk($sformatf("ramp_d1_data_%0d", i), 32'(d1), 32'(i));
            for (int j = 0; j < 32; j++) tick();
        end
        chk("ramp_ovf", 32'(o0), 0);
        chk("ramp_empty", 32'(v0), 0);

        // Fill and overflow: six kept samples -5..0 with out_ready low
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(-5 + k);
            chk($sformatf("fill_count_%0d", k), 32'(c0), 32'((k < 4) ? k + 1 : 4));
            chk($sformatf("fill_ovf_%0d", k), 32'(o0), 32'(k >= 4));
            for (int j = 0; j < 7; j++) send(1000);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid_%0d", k), 32'(v0), 1);
            chk($sformatf("drain_data_%0d", k), 32'(d0), 32'(-5 + k));
            tick();
        end
        chk("drain_empty", 32'(v0), 0);
        chk("drain_count", 32'(c0), 0);

        // Simultaneous push and pop at full
        do_reset();
        out_ready = 1'b0;
        fill4(10);
        chk("full_count", 32'(c0), 4);
        in_valid  = 1'b1;
        data_in   = 16'h7FFF;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(c0), 4);
        chk("pp_ovf",   32'(o0), 0);
        chk("pp_head",  32'(d0), 11);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_drain_%0d", k), 32'(d0), (k < 3) ? 32'(11 + k) : 32'h7FFF);
            tick();
        end
        chk("pp_empty", 32'(v0), 0);

        // Clear vs. set in the same cycle, then clear on an idle cycle
        do_reset();
        out_ready = 1'b0;
        fill4(20);
        clear_overflow = 1'b1;
        send(24);
        chk("clr_vs_set", 32'(o0), 1);
        tick();
        clear_overflow = 1'b0;
        chk("clr_idle", 32'(o0), 0);
        chk("clr_count", 32'(c0), 4);

        // Reset mid-operation: count=3, phase counter at 5
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 21; i++) send(200 + i);
        chk("mid_count_pre", 32'(c0), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_count", 32'(c0), 0);
        chk("mid_valid", 32'(v0), 0);
        chk("mid_data",  32'(d0), 0);
        chk("mid_ovf",   32'(o0), 0);
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        send(77);
        chk("post_rst_valid", 32'(v0), 1);
        chk("post_rst_data",  32'(d0), 77);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_decimator.md
# fir_decimator

Decimation and output-buffer stage that sits directly downstream of the cascaded `fir_module` pair. It accepts the filtered 16-bit sample stream on a one-cycle strobe, keeps one sample in every `DECIM`, and buffers kept samples in a small first-word-fall-through FIFO. The FIFO drains through a valid/ready handshake to the consumer (audio/FFT side). Samples that arrive when the buffer is full are dropped and flagged.

## Interface
- `WIDTH`, 16, sample width; signed two's complement.
- `DECIM`, 8, decimation ratio; must be ≥ 1.
- `PHASE`, 0, index of the kept sample within each group of `DECIM` inputs; must satisfy 0 ≤ `PHASE` < `DECIM`.
- `DEPTH`, 4, FIFO depth in samples; must be a power of two and ≥ 2.

- `clk`  input  1  system clock (100 MHz); all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  input  1  one-cycle strobe from the upstream FIR, `valid_out && enable`.
- `data_in`  input  WIDTH signed  FIR output sample; sampled only when `in_valid`=1.
- `data_out`  output  WIDTH signed  FIFO head sample.
- `out_valid`  output  1  FIFO not empty.
- `out_ready`  input  1  consumer accepts the head sample.
- `count`  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overflow`  output  1  sticky flag: a kept sample was dropped.
- `clear_overflow`  input  1  synchronous clear for `overflow`.

## Operation
- **Phase counter.**
  - Runs 0..DECIM-1 and advances by 1 on each `in_valid`.
  - Wraps from DECIM-1 to 0.
  - Holds while `in_valid`=0.
  - With DECIM=1 it is constantly 0 and every sample is kept.
- **Keep.** A sample is kept when `in_valid`=1 and the phase counter equals `PHASE`, evaluated before the increment.
- **Pop.** `pop` = `out_valid && out_ready`.
- **Push.** `push` = keep && (`count` < DEPTH || `pop`).
  - A full FIFO that pops in the same cycle still accepts the new sample; `count` stays at DEPTH.
- **Drop.** keep && `count`==DEPTH && !`pop`.
  - The sample is discarded and `overflow` is set.
  - The phase counter still advances.
- **Pointers.** Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- **Count.** `count` next = `count` + push − pop.
  - Push and pop in the same cycle leave `count` unchanged.
  - A pop from empty cannot occur, because `out_valid`=0 when empty.
- **FWFT output.**
  - `data_out` = mem[rd_ptr], combinational from registered storage.
  - `out_valid` = (`count` != 0).
  - `data_out` is don't-care when `out_valid`=0 and holds the stale head.
- **Overflow flag.**
  - Set on drop; cleared by `clear_overflow`=1.
  - If a drop and a clear occur in the same cycle, set wins and `overflow`=1.
- **Data path.** `data_in` is stored bit-exact; no rounding or saturation.
- **Reset (`rst`=0, asynchronous).** Returns the block to the idle state regardless of any operation in progress. All of the following are zero:
  - phase counter, pointers, storage;
  - `count`, `out_valid`, `data_out`, `overflow`.

## Timing
- Push-to-output latency is 1 cycle. For a kept sample with `in_valid` at edge N, `out_valid`=1 and `data_out`=sample are visible after edge N when the FIFO was empty.
- Pop takes effect at the edge where `out_valid && out_ready`. The next head, or `out_valid`=0, appears after that edge.
- There is no combinational path from `out_ready` to `out_valid`. `out_ready` may toggle freely.
- `in_valid` is not back-pressured; the upstream FIR never stalls.
- Throughput: one push and one pop per cycle maximum. Nominal input rate is 1 per 33 cycles, which gives one kept sample per 264 cycles at DECIM=8.
- Release from reset is asynchronous assertion with synchronous-safe deassertion. The first `in_valid` after deassertion is phase 0.

## Test plan
- **Basic decimation.** Reset; `out_ready`=1; DECIM=8, PHASE=0; feed ramp 0,1,2,…,31 with `in_valid` every 33 cycles → outputs 0, 8, 16, 24, each appearing 1 cycle after its strobe; `overflow`=0.
- **Phase selection.** PHASE=3 with the same ramp → outputs 3, 11, 19, 27. DECIM=1 → every input appears in order.
- **Fill and overflow.** `out_ready`=0; feed 6 kept samples (−5, −4, …, 0) → `count` goes 1..4 then holds at 4; `overflow`=1 after the 5th kept sample. Raise `out_ready` → −5, −4, −3, −2 drain, then `out_valid`=0.
- **Simultaneous push/pop at full.** `count`=4, `out_ready`=1, kept sample 0x7FFF arrives in the same cycle → `count` stays 4, no overflow, and 0x7FFF appears last.
- **Clear vs. set.** Assert `clear_overflow` in the same cycle as a drop → `overflow` stays 1. Clear on a later idle cycle → `overflow`=0.
- **Reset mid-operation.** Drive `rst` low with `count`=3 and the phase counter at 5 → immediately `count`=0, `out_valid`=0, `data_out`=0, `overflow`=0. After release, the first kept sample is the 1st input when PHASE=0.
